// File: rtl/game_level_fsm.sv
// rtl/game_level_fsm.sv - level progression FSM for a number-guessing game
module game_level_fsm #(
   parameter int LEVELS           = 3,
   parameter int TIMER_W          = 7,
   parameter int TIMER_STEP       = 30,
   parameter int GUESS_W          = 3,
   parameter int GUESS_BASE       = 3,
   parameter int ROUND_W          = 3,
   parameter int ROUNDS_PER_LEVEL = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               key3,
   input  logic [GUESS_W-1:0] guess,
   input  logic [ROUND_W-1:0] round,
   input  logic [TIMER_W-1:0] timer,
   output logic [TIMER_W-1:0] Max_timer,
   output logic [GUESS_W-1:0] Max_guess,
   output logic [2:0]         Max_digit,
   output logic [2:0]         level,
   output logic [1:0]         state,
   output logic               level_clear,
   output logic [2:0]         best
);

   typedef enum logic [1:0] {
      ST_PLAY  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_WIN   = 2'd2,
      ST_OVER  = 2'd3
   } state_t;

   localparam logic [2:0] LAST_LEVEL = 3'(LEVELS - 1);
   localparam logic [2:0] LEVELS_CNT = 3'(LEVELS);

   // Per-level limits, truncated to the output port widths.
   function automatic logic [TIMER_W-1:0] f_max_timer(input logic [2:0] lvl);
      f_max_timer = TIMER_W'(TIMER_STEP * (int'(lvl) + 1));
   endfunction

   function automatic logic [GUESS_W-1:0] f_max_guess(input logic [2:0] lvl);
      f_max_guess = GUESS_W'(GUESS_BASE + int'(lvl));
   endfunction

   function automatic logic [2:0] f_max_digit(input logic [2:0] lvl);
      f_max_digit = 3'(int'(lvl) + 1);
   endfunction

   state_t             r_state;
   logic [2:0]         r_level;
   logic [2:0]         r_best;
   logic               r_level_clear;
   logic               r_key3_q;
   logic [TIMER_W-1:0] r_max_timer;
   logic [GUESS_W-1:0] r_max_guess;
   logic [2:0]         r_max_digit;

   logic               w_restart;
   logic [GUESS_W-1:0] w_guess_lim;
   logic               w_lose;
   logic               w_advance;
   state_t             w_state_nxt;
   logic [2:0]         w_level_nxt;
   logic [2:0]         w_best_nxt;

   // Play-phase conditions: restart is the rising edge of key3, lose outranks advance.
   always_comb begin
      w_restart   = key3 & ~r_key3_q;
      w_guess_lim = f_max_guess(r_level);
      w_lose      = (timer == '0) || (guess > w_guess_lim);
      w_advance   = (timer != '0) && (guess <= w_guess_lim) &&
                    (int'(round) >= ROUNDS_PER_LEVEL);
   end

   // Next-state selection; restart overrides every state and condition.
   always_comb begin
      w_state_nxt = r_state;
      w_level_nxt = r_level;
      w_best_nxt  = r_best;
      if (w_restart) begin
         w_state_nxt = ST_PLAY;
         w_level_nxt = 3'd0;
      end else begin
         case (r_state)
            ST_PLAY: begin
               if (r_level > LAST_LEVEL) begin
                  // a level outside the configured range can only come from upset state
                  w_state_nxt = ST_PLAY;
                  w_level_nxt = 3'd0;
               end else if (w_lose) begin
                  w_state_nxt = ST_OVER;
                  if (r_level > r_best) begin
                     w_best_nxt = r_level;
                  end
               end else if (w_advance) begin
                  if (r_level < LAST_LEVEL) begin
                     w_state_nxt = ST_CLEAR;
                     w_level_nxt = r_level + 3'd1;
                  end else begin
                     w_state_nxt = ST_WIN;
                     w_best_nxt  = LEVELS_CNT;
                  end
               end
            end
            ST_CLEAR: begin
               // one-cycle pause so the game counters can be cleared; inputs ignored
               w_state_nxt = ST_PLAY;
               if (r_level > LAST_LEVEL) begin
                  w_level_nxt = 3'd0;
               end
            end
            ST_WIN, ST_OVER: begin
               w_state_nxt = r_state;
            end
            default: begin
               w_state_nxt = ST_PLAY;
               w_level_nxt = 3'd0;
            end
         endcase
      end
   end

   // State register with outputs registered from the next state, so every output is a flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_PLAY;
         r_level       <= 3'd0;
         r_best        <= 3'd0;
         r_level_clear <= 1'b0;
         r_key3_q      <= 1'b0;
         r_max_timer   <= f_max_timer(3'd0);
         r_max_guess   <= f_max_guess(3'd0);
         r_max_digit   <= f_max_digit(3'd0);
      end else begin
         r_state       <= w_state_nxt;
         r_level       <= w_level_nxt;
         r_best        <= w_best_nxt;
         r_level_clear <= (w_state_nxt == ST_CLEAR);
         r_key3_q      <= key3;
         if ((w_state_nxt == ST_WIN) || (w_state_nxt == ST_OVER)) begin
            r_max_timer <= '0;
            r_max_guess <= '0;
            r_max_digit <= 3'd0;
         end else begin
            r_max_timer <= f_max_timer(w_level_nxt);
            r_max_guess <= f_max_guess(w_level_nxt);
            r_max_digit <= f_max_digit(w_level_nxt);
         end
      end
   end

   assign Max_timer   = r_max_timer;
   assign Max_guess   = r_max_guess;
   assign Max_digit   = r_max_digit;
   assign level       = r_level;
   assign state       = r_state;
   assign level_clear = r_level_clear;
   assign best        = r_best;

endmodule

// File: tb/tb_game_level_fsm.sv
// tb/tb_game_level_fsm.sv - self-checking bench for game_level_fsm
module tb_game_level_fsm;

   localparam int TW   = 7;
   localparam int GW   = 3;
   localparam int RW   = 3;
   localparam int GB   = 3;
   localparam int RPL  = 4;
   localparam int LV_A = 3;
   localparam int ST_A = 30;
   localparam int LV_B = 5;
   localparam int ST_B = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_a, rst_b, key_a, key_b;
   logic [GW-1:0] g_a, g_b;
   logic [RW-1:0] r_a, r_b;
   logic [TW-1:0] t_a, t_b;

   logic [TW-1:0] a_mt, b_mt;
   logic [GW-1:0] a_mg, b_mg;
   logic [2:0]    a_md, b_md, a_lvl, b_lvl, a_best, b_best;
   logic [1:0]    a_st, b_st;
   logic          a_lc, b_lc;

   game_level_fsm u_dut_a (
      .clk(clk), .reset(rst_a), .key3(key_a), .guess(g_a), .round(r_a), .timer(t_a),
      .Max_timer(a_mt), .Max_guess(a_mg), .Max_digit(a_md), .level(a_lvl),
      .state(a_st), .level_clear(a_lc), .best(a_best)
   );

   game_level_fsm #(.LEVELS(LV_B), .TIMER_STEP(ST_B)) u_dut_b (
      .clk(clk), .reset(rst_b), .key3(key_b), .guess(g_b), .round(r_b), .timer(t_b),
      .Max_timer(b_mt), .Max_guess(b_mg), .Max_digit(b_md), .level(b_lvl),
      .state(b_st), .level_clear(b_lc), .best(b_best)
   );

   // Game model: st 0=PLAY 1=CLEAR 2=WIN 3=OVER, pk = key3 seen last cycle
   typedef struct {
      int st;
      int lvl;
      int best;
      int pk;
   } mdl_t;

   function automatic mdl_t mdl_rst();
      mdl_t m;
      m.st = 0; m.lvl = 0; m.best = 0; m.pk = 0;
      return m;
   endfunction

   function automatic mdl_t mdl_step(mdl_t m, int nlev, int k, int g, int r, int t);
      mdl_t n;
      int   budget;
      n    = m;
      n.pk = k;
      if (k == 1 && m.pk == 0) begin
         n.st = 0; n.lvl = 0;
         return n;
      end
      if (m.st == 0) begin
         budget = (GB + m.lvl) % (1 << GW);
         if (t == 0 || g > budget) begin
            n.st = 3;
            if (m.lvl > m.best) n.best = m.lvl;
         end else if (r >= RPL) begin
            if (m.lvl + 1 < nlev) begin
               n.st = 1; n.lvl = m.lvl + 1;
            end else begin
               n.st = 2; n.best = nlev;
            end
         end
      end else if (m.st == 1) begin
         n.st = 0;
      end
      return n;
   endfunction

   mdl_t ma, mb;

   always @(posedge clk or posedge rst_a) begin
      if (rst_a) ma <= mdl_rst();
      else       ma <= mdl_step(ma, LV_A, int'(key_a), int'(g_a), int'(r_a), int'(t_a));
   end

   always @(posedge clk or posedge rst_b) begin
      if (rst_b) mb <= mdl_rst();
      else       mb <= mdl_step(mb, LV_B, int'(key_b), int'(g_b), int'(r_b), int'(t_b));
   end

   int n_vec = 0;
   int n_err = 0;
   bit run_chk = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_inst(input string tag, input mdl_t m, input int step,
                           input int st, input int lvl, input int bst, input int lc,
                           input int mt, input int mg, input int md);
      bit dead;
      dead = (m.st >= 2);
      chk({tag, ".state"},       st,  m.st);
      chk({tag, ".level"},       lvl, m.lvl);
      chk({tag, ".best"},        bst, m.best);
      chk({tag, ".level_clear"}, lc,  (m.st == 1) ? 1 : 0);
      chk({tag, ".Max_timer"},   mt,  dead ? 0 : (step * (m.lvl + 1)) % (1 << TW));
      chk({tag, ".Max_guess"},   mg,  dead ? 0 : (GB + m.lvl) % (1 << GW));
      chk({tag, ".Max_digit"},   md,  dead ? 0 : (m.lvl + 1) % 8);
   endtask

   // Every-cycle comparison of both instances against the model
   always @(negedge clk) begin
      if (run_chk) begin
         chk_inst("A", ma, ST_A, int'(a_st), int'(a_lvl), int'(a_best), int'(a_lc),
                  int'(a_mt), int'(a_mg), int'(a_md));
         chk_inst("B", mb, ST_B, int'(b_st), int'(b_lvl), int'(b_best), int'(b_lc),
                  int'(b_mt), int'(b_mg), int'(b_md));
      end
   end

   task automatic cyc_a(input int k, input int g, input int r, input int t);
      key_a = 1'(k); g_a = GW'(g); r_a = RW'(r); t_a = TW'(t);
      @(negedge clk);
   endtask

   task automatic cyc_b(input int k, input int g, input int r, input int t);
      key_b = 1'(k); g_b = GW'(g); r_b = RW'(r); t_b = TW'(t);
      @(negedge clk);
   endtask

   task automatic pulse_rst_a();
      #2 rst_a = 1'b1;
      @(negedge clk);
      rst_a = 1'b0;
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      key_a = 1'b0; g_a = '0; r_a = '0; t_a = TW'(10);
      key_b = 1'b0; g_b = '0; r_b = '0; t_b = TW'(10);
      @(negedge clk);
      run_chk = 1'b1;
      @(negedge clk);

      // reset values with default parameters
      chk("rst.Max_timer", int'(a_mt), 30);
      chk("rst.Max_guess", int'(a_mg), 3);
      chk("rst.Max_digit", int'(a_md), 1);
      chk("rst.state",     int'(a_st), 0);
      rst_a = 1'b0;
      cyc_a(0, 0, 0, 10);

      // level 0 cleared
      cyc_a(0, 2, 4, 20);
      chk("clr.state",       int'(a_st),  1);
      chk("clr.level",       int'(a_lvl), 1);
      chk("clr.level_clear", int'(a_lc),  1);
      chk("clr.Max_timer",   int'(a_mt),  60);
      chk("clr.Max_guess",   int'(a_mg),  4);
      chk("clr.Max_digit",   int'(a_md),  2);
      cyc_a(0, 2, 4, 20);
      chk("clr2play.state", int'(a_st),  0);
      chk("clr2play.level", int'(a_lvl), 1);
      chk("clr2play.lc",    int'(a_lc),  0);

      // level 1 cleared, then win at level 2 with guess exactly at budget
      cyc_a(0, 2, 4, 20);
      cyc_a(0, 0, 0, 10);
      cyc_a(0, 5, 4, 5);
      chk("win.state",     int'(a_st),   2);
      chk("win.level",     int'(a_lvl),  2);
      chk("win.best",      int'(a_best), 3);
      chk("win.Max_timer", int'(a_mt),   0);
      chk("win.Max_guess", int'(a_mg),   0);
      repeat (3) cyc_a(0, 7, 4, 0);
      cyc_a(1, 0, 0, 10);
      chk("win_restart.state", int'(a_st),   0);
      chk("win_restart.best",  int'(a_best), 3);
      cyc_a(0, 0, 0, 10);

      // timer expiry together with enough rounds at level 1, then held key3
      pulse_rst_a();
      chk("rst2.best", int'(a_best), 0);
      cyc_a(0, 2, 4, 20);
      cyc_a(0, 0, 0, 10);
      cyc_a(0, 0, 4, 0);
      chk("over1.state", int'(a_st),   3);
      chk("over1.best",  int'(a_best), 1);
      cyc_a(1, 0, 0, 10);
      chk("held.first.state", int'(a_st),  0);
      chk("held.first.level", int'(a_lvl), 0);
      cyc_a(1, 2, 4, 20);
      repeat (8) cyc_a(1, 0, 0, 10);
      chk("held.end.level", int'(a_lvl),  1);
      chk("held.end.best",  int'(a_best), 1);
      cyc_a(0, 0, 0, 10);

      // guess over budget at level 0, then key3 pulse mid-play at level 1
      pulse_rst_a();
      cyc_a(0, 4, 0, 10);
      chk("over0.state", int'(a_st),   3);
      chk("over0.best",  int'(a_best), 0);
      cyc_a(1, 0, 0, 10);
      cyc_a(0, 2, 4, 20);
      cyc_a(0, 0, 0, 10);
      cyc_a(1, 0, 0, 10);
      chk("midplay.level", int'(a_lvl),  0);
      chk("midplay.state", int'(a_st),   0);
      chk("midplay.best",  int'(a_best), 0);
      cyc_a(0, 0, 0, 10);

      // restart beats advance; lose beats advance
      cyc_a(1, 2, 4, 20);
      chk("rst_prio.state", int'(a_st), 0);
      cyc_a(0, 4, 4, 10);
      chk("lose_prio.state", int'(a_st), 3);
      cyc_a(1, 0, 0, 10);
      cyc_a(0, 0, 0, 10);

      // asynchronous reset mid-game discards best; first edge after release evaluates level 0
      cyc_a(0, 2, 4, 20);
      cyc_a(0, 0, 0, 10);
      cyc_a(0, 0, 0, 0);
      chk("pre_rst.best", int'(a_best), 1);
      #2 rst_a = 1'b1;
      #1;
      chk("async_a.best",  int'(a_best), 0);
      chk("async_a.state", int'(a_st),   0);
      @(negedge clk);
      rst_a = 1'b0;
      cyc_a(0, 2, 4, 20);
      chk("post_rst.state", int'(a_st),  1);
      chk("post_rst.level", int'(a_lvl), 1);
      cyc_a(0, 0, 0, 10);

      // five-level instance with 20 s steps
      rst_b = 1'b0;
      cyc_b(0, 0, 0, 10);
      repeat (4) begin
         cyc_b(0, 2, 4, 20);
         cyc_b(0, 0, 0, 10);
      end
      chk("b.l4.level",     int'(b_lvl), 4);
      chk("b.l4.Max_timer", int'(b_mt),  100);
      chk("b.l4.Max_guess", int'(b_mg),  7);
      chk("b.l4.Max_digit", int'(b_md),  5);
      cyc_b(0, 2, 4, 20);
      chk("b.win.state", int'(b_st),   2);
      chk("b.win.best",  int'(b_best), 5);
      @(posedge clk);
      #3 rst_b = 1'b1;
      #1;
      chk("b.async.state",     int'(b_st),   0);
      chk("b.async.level",     int'(b_lvl),  0);
      chk("b.async.best",      int'(b_best), 0);
      chk("b.async.lc",        int'(b_lc),   0);
      chk("b.async.Max_timer", int'(b_mt),   20);
      chk("b.async.Max_guess", int'(b_mg),   3);
      chk("b.async.Max_digit", int'(b_md),   1);
      @(negedge clk);
      rst_b = 1'b0;
      cyc_b(0, 0, 0, 10);
      cyc_b(0, 0, 0, 10);

      run_chk = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/game_level_fsm.md
GAME_LEVEL_FSM -- requirements
Module: game_level_fsm

Interface
REQ-001 The block SHALL have parameter LEVELS, default 3, meaning the number of playable difficulty levels (legal range 1..7).
REQ-002 The block SHALL have parameter TIMER_W, default 7, meaning the width of the timer input and the Max_timer output.
REQ-003 The block SHALL have parameter TIMER_STEP, default 30, meaning the seconds added to the time budget per level.
REQ-004 The block SHALL have parameter GUESS_W, default 3, meaning the width of the guess input and the Max_guess output.
REQ-005 The block SHALL have parameter GUESS_BASE, default 3, meaning the guess budget at level 0.
REQ-006 The block SHALL have parameter ROUND_W, default 3, meaning the width of the round input.
REQ-007 The block SHALL have parameter ROUNDS_PER_LEVEL, default 4, meaning the completed rounds required to clear a level.
REQ-008 The block SHALL use one clock; reset is asynchronous and active-high (ports clk, reset).
REQ-009 The block SHALL have the following ports, clock and reset first:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous active-high reset
key3  in  1  restart button, active-high level
guess  in  GUESS_W  guesses used in current round
round  in  ROUND_W  rounds completed in current level
timer  in  TIMER_W  seconds remaining
Max_timer  out  TIMER_W  time budget for current level
Max_guess  out  GUESS_W  guess budget for current level
Max_digit  out  3  digits of target number for current level
level  out  3  current level index, 0-based
state  out  2  PLAY=0, CLEAR=1, WIN=2, OVER=3
level_clear  out  1  one-cycle pulse, counters must be cleared
best  out  3  highest levels-cleared count since reset

Function
REQ-010 Per-level limits SHALL be: Max_timer=TIMER_STEP*(level+1), Max_guess=GUESS_BASE+level, Max_digit=level+1, truncated to port width; these SHALL be 0 in WIN and OVER.
REQ-011 Outputs SHALL decode only registered state (state, level, best, level_clear); no combinational input-to-output path.
REQ-012 key3 SHALL be registered and edge-detected; restart = key3 high this cycle AND low the previous cycle.
REQ-013 Advance condition (PLAY only): timer>0 AND guess<=Max_guess AND round>=ROUNDS_PER_LEVEL.
REQ-014 Lose condition (PLAY only): timer==0 OR guess>Max_guess; lose SHALL take priority over advance.
REQ-015 PLAY with lose SHALL go to OVER on the next edge; best SHALL update to max(best, level) on that same edge.
REQ-016 PLAY with advance and level<LEVELS-1 SHALL go to CLEAR on the next edge with level incremented by 1.
REQ-017 PLAY with advance and level==LEVELS-1 SHALL go to WIN on the next edge, level unchanged, best SHALL update to LEVELS.
REQ-018 CLEAR SHALL last exactly one cycle and return to PLAY; level_clear SHALL be 1 only while state==CLEAR; inputs SHALL be ignored in CLEAR.
REQ-019 WIN and OVER SHALL hold until restart.
REQ-020 Restart in any state SHALL force PLAY, level=0 on the next edge, with priority over all other conditions; best SHALL NOT change on restart.
REQ-021 Neither input holding a condition nor a level-held key3 SHALL cause more than one transition per event.
REQ-022 Unused state encodings SHALL recover to PLAY, level 0.

Reset
REQ-023 Asserting reset SHALL immediately set state=PLAY, level=0, best=0, level_clear=0, and the key3 edge register to 0.
REQ-024 With default parameters, outputs during reset SHALL be Max_timer=30, Max_guess=3, Max_digit=1.
REQ-025 Reset asserted mid-game SHALL discard all progress including best; the first edge after release SHALL evaluate PLAY level 0.

Verification
REQ-026 Defaults: timer=20, guess=2, round=4 in PLAY level 0 -> next edge CLEAR, level=1, level_clear=1, Max_timer=60, Max_guess=4, Max_digit=2; edge after -> PLAY.
REQ-027 Defaults, level 2: timer=5, guess=5, round=4 -> WIN, Max_*=0, best=3.
REQ-028 Level 1: timer=0, round=4 (both conditions) -> OVER, best=1; key3 held high 10 cycles -> single restart to PLAY level 0, best stays 1.
REQ-029 Level 0: guess=4, timer=10 -> OVER, best=0; key3 pulse mid-PLAY at level 1 -> PLAY level 0, best unchanged.
REQ-030 LEVELS=5, TIMER_STEP=20: clear four levels -> level 4 shows Max_timer=100, Max_guess=7, Max_digit=5; reset asserted asynchronously mid-cycle -> all outputs at reset values before the next edge.
